muxdff_lfsr_seq: RTL
====================

Name: muxdff_lfsr_seq

Overview:
- Controller plus state chain that drives a row of mux+DFF stages: WIDTH flip-flops, each fronted by a 2:1 mux that selects the load value (L=1) or the feedback value (L=0).
- Accepts a seed and a step count over a valid/ready handshake. Strobes L for one cycle to parallel-load the seed, then clocks the chain as a Galois LFSR for the requested number of steps.
- Returns the final state over a second valid/ready handshake.
- Sits directly upstream of the per-bit mux+DFF cell and generates its L and r_in controls.

Parameters:
- WIDTH, 3, number of mux+DFF stages (state bits), 2..16.
- TAPS, 3'b110, Galois feedback mask, WIDTH bits, XORed in when the shifted-out bit is 1.
- CNT_W, 8, width of the step counter and steps input.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- seed_valid  in  1  seed/steps offered.
- seed_ready  out  1  block can accept a seed.
- seed  in  WIDTH  initial LFSR state.
- steps  in  CNT_W  number of LFSR advances after the load.
- L  out  1  load strobe to the stage muxes.
- r  out  WIDTH  parallel load data to the stage muxes (r_in of each stage).
- q  out  WIDTH  current chain state (Q of each stage).
- done_valid  out  1  result available.
- done_ready  in  1  consumer takes the result.
- result  out  WIDTH  final chain state.
- lockup  out  1  result is all-zero (degenerate LFSR).

Behaviour:
- Reset: applies at any posedge with reset=1, from any state, including mid-run.
  - Next state IDLE; q=0, r=0, cnt=0.
  - L=0, done_valid=0, lockup=0, seed_ready=0 while reset is high.
  - Any in-flight operation is aborted; no done is issued for it.
- Chain update, every edge: q <= L ? r : next(q).
  - next(q) = (q >> 1) ^ (q[0] ? TAPS : 0), with the MSB shifted in as 0 before the XOR.
  - In IDLE and DONE, q holds: an enable gates the chain and L=0.
- FSM states IDLE, LOAD, RUN, DONE:
  - IDLE: seed_ready=1. On seed_valid & seed_ready: r <= seed, cnt <= steps, go to LOAD. seed_valid is ignored in every other state.
  - LOAD: L=1 for exactly one cycle; q <= r at the edge. If cnt==0, go to DONE; else go to RUN.
  - RUN: L=0. At each edge q <= next(q) and cnt <= cnt-1. Go to DONE on the edge where cnt==1.
  - DONE: done_valid=1, result=q, lockup=(q==0). Hold all outputs stable while done_ready=0. On done_valid & done_ready, go to IDLE.
- Output timing:
  - L and seed_ready decode combinationally from the registered state.
  - r, q, cnt and the state are registered.
  - result equals q; it is meaningful only when done_valid=1 and is stable across a stall.
- Latency:
  - done_valid rises steps+1 edges after the seed-accept edge.
  - Per-job occupancy is steps+2 cycles plus the done stall, plus one IDLE cycle before the next seed is accepted.
  - No overlap: seed_ready=0 from LOAD through DONE.
- Boundaries:
  - steps=0 gives result=seed.
  - steps=255 (max for CNT_W=8) must not wrap the counter early.
  - seed=0 stays 0 forever, giving result=0 and lockup=1.
  - done_ready may already be high when DONE is entered: a single-cycle DONE is legal.
  - Simultaneous reset and handshake: reset wins.
- Width rules: steps is unsigned. cnt never underflows, because RUN is entered only when cnt>=1.

Test Plan:
- Reset then idle (WIDTH=3, TAPS=110) -> during reset q=000, done_valid=0, L=0, seed_ready=0; seed_ready=1 on the first cycle after reset drops.
- seed=001, steps=0 -> L high exactly one cycle; done_valid 1 edge after accept; result=001, lockup=0.
- seed=001, steps=3 -> q sequence 001,110,011,111; done_valid 4 edges after accept; result=111.
- seed=101, steps=7 -> full period 101,100,010,001,110,011,111,101; result=101. Back-to-back job seed=111, steps=1 -> result=101.
- Backpressure: seed=011, steps=2, done_ready=0 for 4 cycles -> result=101 stable, done_valid held, seed_ready=0, a seed_valid pulse during the stall is ignored; completes when done_ready=1.
- Reset asserted during RUN (seed=110, steps=20, reset at cycle 5) -> IDLE next edge, q=000, done_valid never asserts. Separately, seed=000, steps=5 -> result=000, lockup=1.

Source files
------------

// File: rtl/muxdff_lfsr_seq.sv
// Controller and state chain for a row of mux+DFF stages.
// A seed is accepted over a valid/ready handshake and parallel-loaded with a
// one-cycle L strobe. The chain then steps as a Galois LFSR for the requested
// count, and the final state is returned over a second valid/ready handshake.
module muxdff_lfsr_seq #(
    parameter int unsigned      WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = 3'b110,
    parameter int unsigned      CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] steps,
    output logic             L,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] result,
    output logic             lockup
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_next;

    // Galois step: shift right with a zero into the MSB, then fold in the taps
    // when the bit leaving the LSB was set.
    always_comb begin
        q_next = (q >> 1) ^ (q[0] ? TAPS : '0);
    end

    // Handshake and strobe outputs decode from the registered state; reset
    // forces them low so nothing is offered while reset is held.
    assign L          = (state == LOAD) && !reset;
    assign seed_ready = (state == IDLE) && !reset;
    assign done_valid = (state == DONE) && !reset;
    assign result     = q;
    assign lockup     = done_valid && (q == '0);

    // Sequencer plus the chain itself: q loads r on the L cycle, advances in
    // RUN, and holds in IDLE and DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_valid) begin
                        r     <= seed;
                        cnt   <= steps;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    q     <= r;
                    state <= (cnt == '0) ? DONE : RUN;
                end
                RUN: begin
                    q   <= q_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
